// File: rtl/vga_sync_gen.sv
// VGA raster counters, sync pulses, display qualifier and line/frame strobes.
// Define VGA_SYNC_FRAME_CNT_EN to add the 16-bit completed-frame counter.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        VGA_clk,
  input  logic        reset,
  output logic [9:0]  xCount,
  output logic [9:0]  yCount,
  output logic        displayArea,
  output logic        VGA_hSync,
  output logic        VGA_vSync,
  output logic        lineEnd,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic        frameEnd,
  output logic [15:0] frameCount
`else
  output logic        frameEnd
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] Y_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic       x_end;
  logic       y_end;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;

  always_comb begin
    x_end = (xCount == X_LAST);
    y_end = (yCount == Y_LAST);
    x_nxt = x_end ? 10'd0 : xCount + 10'd1;
    y_nxt = yCount;
    if (x_end) begin
      y_nxt = y_end ? 10'd0 : yCount + 10'd1;
    end
  end

  // Flags decode the next counter values so they register alongside them.
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      xCount      <= 10'd0;
      yCount      <= 10'd0;
      displayArea <= 1'b1;
      VGA_hSync   <= ~SYNC_POL;
      VGA_vSync   <= ~SYNC_POL;
      lineEnd     <= 1'b0;
      frameEnd    <= 1'b0;
    end else begin
      xCount      <= x_nxt;
      yCount      <= y_nxt;
      displayArea <= (x_nxt < X_ACT) && (y_nxt < Y_ACT);
      VGA_hSync   <= ((x_nxt >= HS_BEG) && (x_nxt <= HS_END))
                     ? SYNC_POL : ~SYNC_POL;
      VGA_vSync   <= ((y_nxt >= VS_BEG) && (y_nxt <= VS_END))
                     ? SYNC_POL : ~SYNC_POL;
      lineEnd     <= (x_nxt == X_LAST);
      frameEnd    <= (x_nxt == X_LAST) && (y_nxt == Y_LAST);
    end
  end

`ifdef VGA_SYNC_FRAME_CNT_EN
  always_ff @(posedge VGA_clk) begin
    if (reset) begin
      frameCount <= 16'd0;
    end else if (x_end && y_end) begin
      frameCount <= frameCount + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen on a shrunken 20x12 raster.
// Two instances cover both sync polarities.
module tb_vga_sync_gen;

  localparam int HA = 10, HF = 2, HS = 3, HB = 5;
  localparam int VA = 6, VF = 1, VS = 2, VB = 3;
  localparam int HT = 20, VT = 12, FRAME = 240;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] x0, y0, x1, y1;
  logic       d0, hs0, vs0, le0, fe0;
  logic       d1, hs1, vs1, le1, fe1;
`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fc0, fc1;
`endif

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut0 (
    .VGA_clk(clk), .reset(reset),
    .xCount(x0), .yCount(y0), .displayArea(d0),
    .VGA_hSync(hs0), .VGA_vSync(vs0),
    .lineEnd(le0),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frameEnd(fe0), .frameCount(fc0)
`else
    .frameEnd(fe0)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b1)
  ) dut1 (
    .VGA_clk(clk), .reset(reset),
    .xCount(x1), .yCount(y1), .displayArea(d1),
    .VGA_hSync(hs1), .VGA_vSync(vs1),
    .lineEnd(le1),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frameEnd(fe1), .frameCount(fc1)
`else
    .frameEnd(fe1)
`endif
  );

  typedef struct {
    bit rst;
    int cyc;
    int x;
    int y;
    bit d;
    bit hs;
    bit vs;
    bit le;
    bit fe;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      failed++;
      $display("FAIL %s got %0d want %0d", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int x, input int y,
                         input bit d, input bit hs, input bit vs,
                         input bit le, input bit fe);
    chk({nm, " x0"}, int'(x0), x);
    chk({nm, " y0"}, int'(y0), y);
    chk({nm, " disp0"}, int'(d0), int'(d));
    chk({nm, " hs0"}, int'(hs0), int'(hs));
    chk({nm, " vs0"}, int'(vs0), int'(vs));
    chk({nm, " le0"}, int'(le0), int'(le));
    chk({nm, " fe0"}, int'(fe0), int'(fe));
    chk({nm, " x1"}, int'(x1), x);
    chk({nm, " y1"}, int'(y1), y);
    chk({nm, " disp1"}, int'(d1), int'(d));
    chk({nm, " hs1"}, int'(hs1), int'(!hs));
    chk({nm, " vs1"}, int'(vs1), int'(!vs));
    chk({nm, " le1"}, int'(le1), int'(le));
    chk({nm, " fe1"}, int'(fe1), int'(fe));
  endtask

  initial begin
    // Counters and flags are cumulative: each row advances from the last.
    vecs.push_back('{1'b1,  3,  0,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1,  1,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  8,  9,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1, 10,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1, 11,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1, 12,  0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b0,  2, 14,  0, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b0,  1, 15,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  3, 18,  0, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1, 19,  0, 0, 1, 1, 1, 0});
    vecs.push_back('{1'b0,  1,  0,  1, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0, 99, 19,  5, 0, 1, 1, 1, 0});
    vecs.push_back('{1'b0,  1,  0,  6, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0, 19, 19,  6, 0, 1, 1, 1, 0});
    vecs.push_back('{1'b0,  1,  0,  7, 0, 1, 0, 0, 0});
    vecs.push_back('{1'b0, 39, 19,  8, 0, 1, 0, 1, 0});
    vecs.push_back('{1'b0,  1,  0,  9, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0, 58, 18, 11, 0, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1, 19, 11, 0, 1, 1, 1, 1});
    vecs.push_back('{1'b0,  1,  0,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0, 53, 13,  2, 0, 0, 1, 0, 0});
    vecs.push_back('{1'b1,  1,  0,  0, 1, 1, 1, 0, 0});
    vecs.push_back('{1'b0,  1,  1,  0, 1, 1, 1, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      reset = vecs[i].rst;
      repeat (vecs[i].cyc) @(posedge clk);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
              vecs[i].d, vecs[i].hs, vecs[i].vs,
              vecs[i].le, vecs[i].fe);
    end
`ifdef VGA_SYNC_FRAME_CNT_EN
    chk("fc0 after reset", int'(fc0), 0);
    chk("fc1 after reset", int'(fc1), 0);
`endif

    // Mid-line reset, then two whole frames against a counter model.
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    begin
      int mx, my, mfc;
      int hs_n, vs_n, le_n, fe_n, first_fe;
      mx = 0; my = 0; mfc = 0;
      hs_n = 0; vs_n = 0; le_n = 0; fe_n = 0; first_fe = -1;
      for (int k = 0; k < 2 * FRAME; k++) begin
        bit ed, ehs, evs, ele, efe;
        ed  = (mx < HA) && (my < VA);
        ehs = !((mx >= 12) && (mx <= 14));
        evs = !((my >= 7) && (my <= 8));
        ele = (mx == HT - 1);
        efe = (mx == HT - 1) && (my == VT - 1);
        chk_all($sformatf("scan%0d", k), mx, my, ed, ehs, evs, ele, efe);
`ifdef VGA_SYNC_FRAME_CNT_EN
        chk($sformatf("scan%0d fc0", k), int'(fc0), mfc);
        chk($sformatf("scan%0d fc1", k), int'(fc1), mfc);
`endif
        if (!hs0) hs_n++;
        if (!vs0) vs_n++;
        if (le0) le_n++;
        if (fe0) begin
          fe_n++;
          if (first_fe < 0) first_fe = k;
        end
        @(posedge clk);
        @(negedge clk);
        if (mx == HT - 1) begin
          mx = 0;
          if (my == VT - 1) begin
            my = 0;
            mfc++;
          end else begin
            my++;
          end
        end else begin
          mx++;
        end
      end
      chk("hsync cycles", hs_n, 2 * VT * HS);
      chk("vsync cycles", vs_n, 2 * VS * HT);
      chk("lineEnd count", le_n, 2 * VT);
      chk("frameEnd count", fe_n, 2);
      chk("frame length", first_fe + 1, FRAME);
`ifdef VGA_SYNC_FRAME_CNT_EN
      chk("fc0 end", int'(fc0), 2);
`endif
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
